pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline boundary register for the in-order core. It supersedes the fixed per-stage latch blocks such as the MEM/WB register. It carries a control bundle, a data bundle and a destination register index between two stages. Adds what the fixed latches lack: a valid bit, ready/valid backpressure with an optional skid entry, synchronous flush, bubble-safe control masking and saturating stall/bubble performance counters.

Parameters:
CTRL_W, 4, width of control bundle (regWrt, memWrt, rsltSrc...)
DATA_W, 128, width of packed data bundle (readD, pc4, ujWrtBck, aluRslt)
RD_W, 5, destination register index width
SKID, 1, 1 = two-entry skid buffer, registered in_ready; 0 = single entry, combinational in_ready
CNT_W, 16, performance counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream stage presents a valid instruction
in_ready  output  1  stage can accept this cycle
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
in_rd  input  RD_W  upstream destination register
flush  input  1  synchronous kill of all held entries
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts this cycle
out_ctrl  output  CTRL_W  control bundle, forced 0 when out_valid=0
out_data  output  DATA_W  data bundle of main entry
out_rd  output  RD_W  destination register of main entry
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  output  CNT_W  cycles with out_valid=0

Behaviour:
- Reset (async, rst=1): main_v=0, skid_v=0, all entry registers 0, counters 0. Outputs: out_valid=0, out_ctrl=0, out_data=0, out_rd=0, in_ready=1 (SKID=1) or in_ready=1 (SKID=0, out_valid=0). Reset mid-transfer discards both entries.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready. Latency: accepted word visible at out_* the cycle after accept (1 cycle).
- out_* always driven from the main entry. out_ctrl = main_v ? main_ctrl : 0, so regWrt/memWrt never fire on a bubble. out_data/out_rd retain their last value when invalid.
- SKID=0: in_ready = !main_v || out_ready (combinational). On accept, main loads in_*. Otherwise, on drain, main_v clears.
- SKID=1: states EMPTY (main_v=0), FULL (main_v=1, skid_v=0), SKID (both valid). in_ready = !skid_v (from register only, no comb path from out_ready).
  - EMPTY: accept -> FULL, main loads in_*.
  - FULL: accept & drain -> FULL, main loads in_*. Accept & !drain -> SKID, skid loads in_*. !accept & drain -> EMPTY. Else hold.
  - SKID: no accept possible. Drain -> FULL, main loads skid entry. Else hold.
  - Ordering is strictly FIFO. No entry is ever duplicated or dropped except by flush/reset.
- Flush (sync) has priority over everything. Next cycle main_v=0 and skid_v=0. Any in_* accepted in the flush cycle is discarded. A drain in the flush cycle still counts as completed downstream. Entry data registers are not cleared.
- Counters: each cycle not in reset, stall_cnt += (out_valid && !out_ready), bubble_cnt += !out_valid. Both saturate at 2^CNT_W-1. They are cleared only by rst; flush does not clear them.
- Data registers load only on their load condition (no enable-free capture). Hold is exact when stalled.

Test Plan:
- Reset then stream: in_valid=1 with in_data=1,2,3 on consecutive cycles, out_ready=1 -> out_data=1,2,3 one cycle later each, out_valid=1 continuously, in_ready stays 1, stall_cnt=0.
- Backpressure (SKID=1): send A,B, hold out_ready=0 for 3 cycles -> state SKID, in_ready=0 after B, out_data=A held, stall_cnt=3. Release -> A then B drained in order, in_ready returns 1 the cycle after A drains.
- Bubble masking: in_ctrl=4'b1111 accepted, then in_valid=0 -> after drain out_valid=0, out_ctrl=0, out_rd unchanged, bubble_cnt increments each idle cycle.
- Flush with skid full and simultaneous in_valid=1 (in_data=C) -> next cycle out_valid=0, in_ready=1, C never appears at the output.
- Async reset asserted mid-cycle while in state SKID -> out_valid=0 immediately (before the next clk edge), both counters 0, in_ready=1.
- Saturation with CNT_W=4: 20 stalled cycles -> stall_cnt=15 and holds. SKID=0 variant: in_ready follows out_ready combinationally while main_v=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with a valid bit, ready/valid backpressure, an optional
// skid entry, a synchronous flush and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 128,
    parameter int RD_W   = 5,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;

    logic main_v, skid_v, accept, drain;

    assign main_v = (state_q != ST_EMPTY);
    assign skid_v = (state_q == ST_SKID);

    // The skid variant breaks the out_ready -> in_ready path; the single-entry
    // variant passes it through so a full stage can still stream every cycle.
    assign in_ready = SKID ? !skid_v : (!main_v || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = main_v && out_ready;

    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign out_rd    = main_rd_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        main_rd_d   = in_rd;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        main_rd_d   = in_rd;
                    end else if (accept) begin
                        state_d     = ST_SKID;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        skid_rd_d   = in_rd;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        main_rd_d   = skid_rd_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_rd_q   <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
        end
    end

    // Index 0 counts stalls, index 1 counts bubbles; both stick at all-ones.
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[0] = out_valid && !out_ready;
    assign cnt_inc[1] = !out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}}))
                    cnt_d = cnt_q + CNT_W'(1);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign stall_cnt  = cnt_val[0];
    assign bubble_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a skid instance (4-bit counters) checked through a scoreboard,
// plus a single-entry instance checked for its combinational in_ready.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
    logic [3:0]   in_ctrl = 0, out_ctrl, stall_cnt, bubble_cnt;
    logic [127:0] in_data = 0, out_data;
    logic [4:0]   in_rd = 0, out_rd;

    logic         s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
    logic [3:0]   s_in_ctrl = 0, s_out_ctrl;
    logic [127:0] s_in_data = 0, s_out_data;
    logic [4:0]   s_in_rd = 0, s_out_rd;
    logic [15:0]  s_stall_cnt, s_bubble_cnt;

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(128), .RD_W(5), .SKID(1'b1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_rd(out_rd), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(128), .RD_W(5), .SKID(1'b0), .CNT_W(16)) dut_ns (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ctrl(s_in_ctrl), .in_data(s_in_data), .in_rd(s_in_rd), .flush(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .out_rd(s_out_rd), .stall_cnt(s_stall_cnt),
        .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic [3:0]   c;
        logic [127:0] d;
        logic [4:0]   r;
    } item_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every downstream handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_drain", out_data, 128'hDEAD);
            end else begin
                item_t it;
                it = exp_q.pop_front();
                check("drain_data", out_data, it.d);
                check("drain_ctrl", {124'd0, out_ctrl}, {124'd0, it.c});
                check("drain_rd", {123'd0, out_rd}, {123'd0, it.r});
            end
        end
    end

    // One clock of stimulus; records accepted words for the monitor.
    task automatic step(input logic v, input logic [3:0] c, input logic [127:0] d,
                        input logic [4:0] r, input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        in_rd     = r;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (fl) exp_q.delete();
        else if (v && in_ready) exp_q.push_back(item_t'{c, d, r});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'h0, 128'h0, 5'h0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 0; flush = 0; out_ready = 0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_ctrl", {124'd0, out_ctrl}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_rd", {123'd0, out_rd}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_stall", {124'd0, stall_cnt}, 128'd0);
        check("rst_bubble", {124'd0, bubble_cnt}, 128'd0);
        rst = 1'b0;

        // Streaming at full rate
        do_reset();
        step(1'b1, 4'h1, 128'd1, 5'd1, 1'b1, 1'b0);
        check("stream1_valid", {127'd0, out_valid}, 128'd1);
        check("stream1_data", out_data, 128'd1);
        step(1'b1, 4'h2, 128'd2, 5'd2, 1'b1, 1'b0);
        check("stream2_data", out_data, 128'd2);
        check("stream2_in_ready", {127'd0, in_ready}, 128'd1);
        step(1'b1, 4'h3, 128'd3, 5'd3, 1'b1, 1'b0);
        check("stream3_data", out_data, 128'd3);
        idle(1'b1);
        check("stream_stall", {124'd0, stall_cnt}, 128'd0);
        check("stream_bubble", {124'd0, bubble_cnt}, 128'd1);

        // Backpressure into the skid entry, then ordered release and bubble masking
        do_reset();
        step(1'b1, 4'hF, 128'hA, 5'd7, 1'b0, 1'b0);
        step(1'b1, 4'hA, 128'hB, 5'd9, 1'b0, 1'b0);
        check("bp_in_ready_after_b", {127'd0, in_ready}, 128'd0);
        idle(1'b0);
        idle(1'b0);
        check("bp_hold_data", out_data, 128'hA);
        check("bp_stall", {124'd0, stall_cnt}, 128'd3);
        idle(1'b1);
        check("bp_in_ready_back", {127'd0, in_ready}, 128'd1);
        check("bp_next_data", out_data, 128'hB);
        idle(1'b1);
        check("mask_valid", {127'd0, out_valid}, 128'd0);
        check("mask_ctrl", {124'd0, out_ctrl}, 128'd0);
        check("mask_rd_kept", {123'd0, out_rd}, 128'd9);
        idle(1'b1);
        idle(1'b1);
        check("mask_bubble", {124'd0, bubble_cnt}, 128'd3);

        // Flush with both entries full and a word offered
        do_reset();
        step(1'b1, 4'h1, 128'h11, 5'd1, 1'b0, 1'b0);
        step(1'b1, 4'h2, 128'h22, 5'd2, 1'b0, 1'b0);
        step(1'b1, 4'h3, 128'hC, 5'd3, 1'b0, 1'b1);
        check("flush_valid", {127'd0, out_valid}, 128'd0);
        check("flush_in_ready", {127'd0, in_ready}, 128'd1);
        idle(1'b1);
        idle(1'b1);
        // Flush discarding a word accepted in the same cycle
        step(1'b1, 4'h4, 128'hD, 5'd4, 1'b0, 1'b0);
        step(1'b1, 4'h5, 128'hE, 5'd5, 1'b0, 1'b1);
        check("flush_accept_valid", {127'd0, out_valid}, 128'd0);
        // Flush while the held word drains
        step(1'b1, 4'h6, 128'hF0, 5'd6, 1'b0, 1'b0);
        step(1'b1, 4'h7, 128'hF1, 5'd7, 1'b1, 1'b1);
        check("flush_drain_valid", {127'd0, out_valid}, 128'd0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset between edges while both entries are full
        do_reset();
        step(1'b1, 4'h1, 128'h31, 5'd1, 1'b0, 1'b0);
        step(1'b1, 4'h2, 128'h32, 5'd2, 1'b0, 1'b0);
        in_valid = 0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_valid", {127'd0, out_valid}, 128'd0);
        check("arst_in_ready", {127'd0, in_ready}, 128'd1);
        check("arst_stall", {124'd0, stall_cnt}, 128'd0);
        check("arst_bubble", {124'd0, bubble_cnt}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Stall counter saturation
        do_reset();
        step(1'b1, 4'h9, 128'h99, 5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        check("sat_stall", {124'd0, stall_cnt}, 128'd15);
        idle(1'b0);
        check("sat_stall_hold", {124'd0, stall_cnt}, 128'd15);
        idle(1'b1);

        // Single-entry variant: in_ready tracks out_ready while holding a word
        do_reset();
        s_in_valid = 1'b1; s_in_data = 128'h55; s_in_ctrl = 4'h3; s_in_rd = 5'd3;
        s_out_ready = 1'b0;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("ns_valid", {127'd0, s_out_valid}, 128'd1);
        check("ns_data", s_out_data, 128'h55);
        #1;
        check("ns_in_ready_low", {127'd0, s_in_ready}, 128'd0);
        s_out_ready = 1'b1;
        #1;
        check("ns_in_ready_high", {127'd0, s_in_ready}, 128'd1);
        s_in_valid = 1'b1; s_in_data = 128'h66;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("ns_passthru_data", s_out_data, 128'h66);
        @(posedge clk); #1;
        check("ns_drained", {127'd0, s_out_valid}, 128'd0);
        check("ns_bubble", {112'd0, s_bubble_cnt}, 128'd1);

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
